// File: rtl/wb_stage_if.sv
// MEM/WB stage bundle: hazard controls, MEM-stage results, data-memory read word
// and the register-file write port produced by wb_stage.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface wb_stage_if #(
    parameter int DW        = `DATA_WIDTH,
    parameter int INSTRET_W = 32
);
    logic                 stall;
    logic                 flush;
    logic                 mem_valid;
    logic                 mem_regwrite;
    logic                 mem_memtoreg;
    logic                 mem_link;
    logic [2:0]           mem_load_type;
    logic [4:0]           mem_waddr;
    logic [DW-1:0]        mem_alu_result;
    logic [DW-1:0]        mem_pc;
    logic [DW-1:0]        dmem_rdata;
    logic [4:0]           waddr;
    logic [DW-1:0]        wdata;
    logic                 WEN;
    logic                 wb_valid;
    logic                 wb_misalign;
    logic [INSTRET_W-1:0] instret;

    modport master (
        output stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_link,
               mem_load_type, mem_waddr, mem_alu_result, mem_pc, dmem_rdata,
        input  waddr, wdata, WEN, wb_valid, wb_misalign, instret
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_link,
               mem_load_type, mem_waddr, mem_alu_result, mem_pc, dmem_rdata,
        output waddr, wdata, WEN, wb_valid, wb_misalign, instret
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load formatting, writeback select, regfile write
// port and retired-instruction counter for the 5-stage MIPS pipeline.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_stage #(
    parameter int DW        = `DATA_WIDTH,
    parameter int INSTRET_W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    wb_stage_if.slave    bus
);

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memtoreg;
        logic          link;
        logic [2:0]    load_type;
        logic [4:0]    waddr;
        logic [DW-1:0] alu_result;
        logic [DW-1:0] pc;
    } stage_t;

    stage_t               stage_q, stage_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [1:0]    off;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;
    logic          is_byte, is_half, is_word;
    logic          misalign;
    logic          retire;

    // Stall wins over flush so a held instruction is never lost to a bubble.
    always_comb begin
        stage_d = stage_q;
        if (!bus.stall) begin
            if (bus.flush) begin
                stage_d = '0;
            end else begin
                stage_d = '{valid:      bus.mem_valid,
                            regwrite:   bus.mem_regwrite,
                            memtoreg:   bus.mem_memtoreg,
                            link:       bus.mem_link,
                            load_type:  bus.mem_load_type,
                            waddr:      bus.mem_waddr,
                            alu_result: bus.mem_alu_result,
                            pc:         bus.mem_pc};
            end
        end
    end

    assign retire    = stage_q.valid & ~bus.stall;
    assign instret_d = retire ? instret_q + 1'b1 : instret_q;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_q   <= '0;
            instret_q <= '0;
        end else begin
            stage_q   <= stage_d;
            instret_q <= instret_d;
        end
    end

    assign off     = stage_q.alu_result[1:0];
    assign ld_byte = bus.dmem_rdata[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    assign is_byte = (stage_q.load_type == LT_LB) || (stage_q.load_type == LT_LBU);
    assign is_half = (stage_q.load_type == LT_LH) || (stage_q.load_type == LT_LHU);
    assign is_word = ~is_byte & ~is_half;

    // NOTE: the default arm assigns ld_data on every path, so no latch is inferred.
    always_comb begin
        case (stage_q.load_type)
            LT_LB:   ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
            LT_LBU:  ld_data = {{(DW-8){1'b0}}, ld_byte};
            LT_LH:   ld_data = {{(DW-16){ld_half[15]}}, ld_half};
            LT_LHU:  ld_data = {{(DW-16){1'b0}}, ld_half};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    assign misalign = stage_q.valid & stage_q.memtoreg &
                      ((is_half & off[0]) | (is_word & (off != 2'b00)));

    assign bus.waddr       = stage_q.waddr;
    assign bus.wdata       = stage_q.link     ? stage_q.pc + DW'(8) :
                             stage_q.memtoreg ? ld_data : stage_q.alu_result;
    assign bus.WEN         = stage_q.valid & stage_q.regwrite & (stage_q.waddr != 5'd0) &
                             ~bus.stall & ~misalign;
    assign bus.wb_valid    = stage_q.valid;
    assign bus.wb_misalign = misalign;
    assign bus.instret     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, load formatting, misalignment,
// link/r0, stall/flush interplay and retired-instruction counter wrap.
module tb_wb_stage;

    logic CLK = 1'b0;
    logic RST;
    logic rst2;

    always #5 CLK = ~CLK;

    wb_stage_if #(.DW(32), .INSTRET_W(32)) bus ();
    wb_stage_if #(.DW(32), .INSTRET_W(4))  bus2 ();

    wb_stage #(.DW(32), .INSTRET_W(32)) dut  (.CLK(CLK), .RST(RST),  .bus(bus));
    wb_stage #(.DW(32), .INSTRET_W(4))  dut2 (.CLK(CLK), .RST(rst2), .bus(bus2));

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected retire count and WB occupancy, advanced once per clock edge.
    logic [31:0] exp_instret = '0;
    logic        exp_valid   = 1'b0;

    task automatic step();
        if (RST) begin
            exp_instret = '0;
            exp_valid   = 1'b0;
        end else begin
            if (exp_valid && !bus.stall) exp_instret = exp_instret + 1;
            if (!bus.stall) exp_valid = bus.flush ? 1'b0 : bus.mem_valid;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                         input logic [2:0] lt, input logic [4:0] wa,
                         input logic [31:0] alu, input logic [31:0] pc);
        bus.mem_valid      = v;
        bus.mem_regwrite   = rw;
        bus.mem_memtoreg   = m2r;
        bus.mem_link       = lnk;
        bus.mem_load_type  = lt;
        bus.mem_waddr      = wa;
        bus.mem_alu_result = alu;
        bus.mem_pc         = pc;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  5'($urandom_range(1, 31)), $urandom, $urandom);
            step();
        end
        tests_run++;
        if (bus.WEN !== 1'b0 || bus.wb_valid !== 1'b0 || bus.wb_misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: WEN=%b wb_valid=%b misalign=%b, want 0/0/0",
                     bus.WEN, bus.wb_valid, bus.wb_misalign);
        end
        tests_run++;
        if (bus.instret !== 32'h0 || bus.waddr !== 5'd0 || bus.wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: instret=%h waddr=%0d wdata=%h, want 0/0/0",
                     bus.instret, bus.waddr, bus.wdata);
        end
        RST = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'h0000_0042, 32'h0040_0000);
        step();
        tests_run++;
        if (bus.waddr !== 5'd3 || bus.wdata !== 32'h42 || bus.WEN !== 1'b1 || bus.instret !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_add: waddr=%0d wdata=%h WEN=%b instret=%h, want 3/00000042/1/0",
                     bus.waddr, bus.wdata, bus.WEN, bus.instret);
        end
        bubble();
        step();
        tests_run++;
        if (bus.instret !== 32'h1 || bus.WEN !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_retire: instret=%h WEN=%b, want 1/0", bus.instret, bus.WEN);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lt_t  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd4, 3'd7};
        logic [1:0]  off_t [8] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
        logic [31:0] exp_t [8] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                                   32'h80FF_7F01, 32'h0000_0001, 32'h0000_80FF, 32'h80FF_7F01};
        bus.dmem_rdata = 32'h80FF_7F01;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, lt_t[i], 5'd5, {30'h0400_0000, off_t[i]}, 32'h0040_0100);
            step();
            tests_run++;
            if (bus.wdata !== exp_t[i] || bus.WEN !== 1'b1 || bus.wb_misalign !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_%0d (type %0d off %0d): wdata=%h WEN=%b misalign=%b, want %h/1/0",
                         i, lt_t[i], off_t[i], bus.wdata, bus.WEN, bus.wb_misalign, exp_t[i]);
            end
        end
        bubble();
        step();
        tests_run++;
        if (bus.instret !== exp_instret || bus.instret !== 32'd9) begin
            tests_failed++;
            $display("FAIL load_instret: instret=%0d, want 9", bus.instret);
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  lt_t  [3] = '{3'd3, 3'd0, 3'd4};
        logic [1:0]  off_t [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] base;
        base = exp_instret;
        bus.dmem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, lt_t[i], 5'd6, {30'h0, off_t[i]}, 32'h0);
            step();
            tests_run++;
            if (bus.wb_misalign !== 1'b1 || bus.WEN !== 1'b0 || bus.wb_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL misalign_%0d: misalign=%b WEN=%b wb_valid=%b, want 1/0/1",
                         i, bus.wb_misalign, bus.WEN, bus.wb_valid);
            end
        end
        // Odd address on a non-load is not a misaligned access.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 5'd6, 32'h0000_0003, 32'h0);
        step();
        tests_run++;
        if (bus.wb_misalign !== 1'b0 || bus.WEN !== 1'b1 || bus.wdata !== 32'h3) begin
            tests_failed++;
            $display("FAIL misalign_alu: misalign=%b WEN=%b wdata=%h, want 0/1/00000003",
                     bus.wb_misalign, bus.WEN, bus.wdata);
        end
        bubble();
        step();
        tests_run++;
        if (bus.instret !== base + 32'd4) begin
            tests_failed++;
            $display("FAIL misalign_retire: instret=%0d, want %0d", bus.instret, base + 32'd4);
        end
    endtask

    task automatic test_link_r0();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 5'd31, 32'h0000_1234, 32'h0040_0010);
        step();
        tests_run++;
        if (bus.wdata !== 32'h0040_0018 || bus.WEN !== 1'b1 || bus.waddr !== 5'd31) begin
            tests_failed++;
            $display("FAIL jal: wdata=%h WEN=%b waddr=%0d, want 00400018/1/31",
                     bus.wdata, bus.WEN, bus.waddr);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 5'd31, 32'h0000_0000, 32'hFFFF_FFFC);
        step();
        tests_run++;
        if (bus.wdata !== 32'h0000_0004 || bus.WEN !== 1'b1) begin
            tests_failed++;
            $display("FAIL link_wrap: wdata=%h WEN=%b, want 00000004/1", bus.wdata, bus.WEN);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0000_0055, 32'h0);
        step();
        tests_run++;
        if (bus.WEN !== 1'b0 || bus.wb_valid !== 1'b1 || bus.waddr !== 5'd0 || bus.wdata !== 32'h55) begin
            tests_failed++;
            $display("FAIL r0_write: WEN=%b wb_valid=%b waddr=%0d wdata=%h, want 0/1/0/00000055",
                     bus.WEN, bus.wb_valid, bus.waddr, bus.wdata);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] held;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd7, 32'h0000_CAFE, 32'h0);
        step();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd9, 32'h0000_BEEF, 32'h0);
        #1;
        held = exp_instret;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus.WEN !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wdata !== 32'hCAFE ||
                bus.instret !== held) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: WEN=%b wb_valid=%b wdata=%h instret=%0d, want 0/1/0000cafe/%0d",
                         i, bus.WEN, bus.wb_valid, bus.wdata, bus.instret, held);
            end
            step();
        end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bubble();
        #1;
        tests_run++;
        if (bus.WEN !== 1'b1 || bus.wdata !== 32'hCAFE || bus.waddr !== 5'd7) begin
            tests_failed++;
            $display("FAIL stall_release: WEN=%b wdata=%h waddr=%0d, want 1/0000cafe/7",
                     bus.WEN, bus.wdata, bus.waddr);
        end
        step();
        tests_run++;
        if (bus.WEN !== 1'b0 || bus.instret !== held + 32'd1) begin
            tests_failed++;
            $display("FAIL stall_once: WEN=%b instret=%0d, want 0/%0d", bus.WEN, bus.instret, held + 32'd1);
        end
        bus.flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd9, 32'h0000_BEEF, 32'h0);
        step();
        bus.flush = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b0 || bus.WEN !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_bubble: wb_valid=%b WEN=%b, want 0/0", bus.wb_valid, bus.WEN);
        end
        // Reset asserted while stalled still clears the stage.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd4, 32'h1, 32'h0);
        step();
        bus.stall = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        bus.stall = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b0 || bus.WEN !== 1'b0 || bus.instret !== 32'h0 || exp_instret !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_in_stall: wb_valid=%b WEN=%b instret=%0d, want 0/0/0",
                     bus.wb_valid, bus.WEN, bus.instret);
        end
        bubble();
        step();
    endtask

    task automatic test_wrap();
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        bus2.mem_valid = 1'b1;
        for (int i = 0; i < 16; i++) step();
        tests_run++;
        if (bus2.instret !== 4'hF) begin
            tests_failed++;
            $display("FAIL wrap_allones: instret=%h, want f", bus2.instret);
        end
        step();
        tests_run++;
        if (bus2.instret !== 4'h0) begin
            tests_failed++;
            $display("FAIL wrap_zero: instret=%h, want 0", bus2.instret);
        end
        bus2.mem_valid = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        rst2       = 1'b1;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        bus.dmem_rdata = 32'h0;
        bubble();
        bus2.stall          = 1'b0;
        bus2.flush          = 1'b0;
        bus2.mem_valid      = 1'b0;
        bus2.mem_regwrite   = 1'b0;
        bus2.mem_memtoreg   = 1'b0;
        bus2.mem_link       = 1'b0;
        bus2.mem_load_type  = 3'd0;
        bus2.mem_waddr      = 5'd0;
        bus2.mem_alu_result = 32'h0;
        bus2.mem_pc         = 32'h0;
        bus2.dmem_rdata     = 32'h0;
        test_reset();
        test_loads();
        test_misalign();
        test_link_r0();
        test_stall_flush();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback-data formatting for the 5-stage MIPS pipeline.
- Captures MEM-stage results and formats load data (byte/halfword extract, sign/zero extend).
- Selects the writeback value and drives the register-file write port (waddr, wdata, WEN) directly.
- Also exports a retired-instruction counter.

Parameters:
- DW, `DATA_WIDTH (32), datapath width; all data/address ports use this.
- INSTRET_W, 32, width of retired-instruction counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- stall  in  1  hazard unit: hold WB register contents.
- flush  in  1  insert bubble into WB on next capture.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_regwrite  in  1  instruction writes a GPR.
- mem_memtoreg  in  1  writeback value comes from data memory.
- mem_link  in  1  JAL/JALR/BGEZAL-type: writeback value is pc+8.
- mem_load_type  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU; 5-7 treated as LW.
- mem_waddr  in  5  destination GPR.
- mem_alu_result  in  DW  ALU result / effective address.
- mem_pc  in  DW  PC of the instruction.
- dmem_rdata  in  DW  synchronous data-memory read word; valid in the WB cycle, aligned with the registered stage.
- waddr  out  5  regfile write address.
- wdata  out  DW  regfile write data.
- WEN  out  1  regfile write enable.
- wb_valid  out  1  WB holds a real instruction (for forwarding/hazard).
- wb_misalign  out  1  current WB load is misaligned.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Stage register (valid, regwrite, memtoreg, link, load_type, waddr, alu_result, pc) updates on posedge CLK only.
- Update priority:
  - RST=1: all fields cleared to 0; instret cleared to 0.
  - else stall=1: hold all fields, regardless of flush.
  - else flush=1: valid<=0; other fields don't-care (cleared to 0).
  - else: capture mem_* inputs.
- Reset outputs: waddr=0, wdata=0, WEN=0, wb_valid=0, wb_misalign=0, instret=0.
- Latency: one cycle from MEM inputs to WB outputs. The write lands in the regfile at the edge ending the WB cycle; same-cycle readers obtain the value through the regfile's internal forwarding.
- Load formatting (little-endian), with off = wb_alu_result[1:0]:
  - LW: whole word; off ignored.
  - LB/LBU: byte lane off; sign-/zero-extend to DW.
  - LH/LHU: halfword lane off[1]; sign-/zero-extend.
- Misalignment:
  - wb_misalign = wb_valid & memtoreg & ((LH/LHU & off[0]) | (LW-class & off!=0)).
  - A misaligned load still formats using the lanes above but has WEN suppressed.
- wdata mux priority: link -> wb_pc+8 (modulo 2^DW) > memtoreg -> formatted load > alu_result. wdata is driven even when WEN=0.
- WEN = wb_valid & wb_regwrite & (waddr!=0) & ~stall & ~wb_misalign. No write is issued while stalled, so a held instruction writes exactly once, in the cycle it is released.
- waddr = registered waddr, unmasked.
- Retire event = wb_valid & ~stall, independent of regwrite (stores/branches count).
  - instret increments by 1 per retire event.
  - instret wraps from all-ones to 0.
  - A misaligned load still retires.
- Reset mid-stall or mid-flush: RST dominates; the next cycle shows a bubble.
- All outputs are functions of registered state plus dmem_rdata and stall. There is no combinational path from mem_* inputs.

Test Plan:
- Reset: drive random mem_* with RST=1 for 2 cycles -> WEN=0, wb_valid=0, instret=0; first non-reset capture of ADD r3 (alu_result=0x0000_0042) -> next cycle waddr=3, wdata=0x42, WEN=1, instret=1 one edge later.
- Loads: dmem_rdata=0x80FF_7F01:
  - LB off=3 -> wdata=0xFFFF_FF80.
  - LBU off=1 -> 0x0000_007F.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
- Misalign: LH off=1 or LW off=2 with regwrite=1 -> wb_misalign=1, WEN=0; instret still increments.
- Link/r0: JAL with mem_pc=0x0040_0010, waddr=31 -> wdata=0x0040_0018, WEN=1; ADD to waddr=0 -> WEN=0, wb_valid=1.
- Stall/flush: valid write held under stall for 3 cycles with flush=1 -> WEN=0 and instret unchanged during stall; after release, exactly one WEN=1 cycle with the original data and instret+1; then flush=1, stall=0 -> next cycle wb_valid=0, WEN=0.
- Wrap: preload instret to 0xFFFF_FFFF via 2^32-1 retires (or a force in the bench), one more retire -> instret=0.
